// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - SW/SH/SB store unit with read-modify-write for sub-word stores
// Merges the register value into the addressed memory word and reports done/err to the control unit.
module store_size_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam logic [1:0] RD_LAT  = 2'(MEM_RD_LAT);

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [1:0]  size_q;
  logic [1:0]  ofs_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;
  logic        accept;
  logic        capture;

  // Replace only the addressed lane of the word read back from memory.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_HALF) begin
      if (ofs_q[1]) merged[31:16] = wdata_q[15:0];
      else          merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{ofs_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (size == SZ_RSVD || (size == SZ_HALF && addr[0])) begin
            state_nx = ERR;
          end else if (size == SZ_WORD) begin
            state_nx = WRITE;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = RD_LAT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt <= 2'd1) begin
          capture  = 1'b1;
          cnt_nx   = 2'd0;
          state_nx = WRITE;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      size_q    <= 2'd0;
      ofs_q     <= 2'd0;
      wdata_q   <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mem_wr <= (state_nx == WRITE);
      busy   <= (state_nx != IDLE);
      done   <= (state_nx == DONE) || (state_nx == ERR);
      err    <= (state_nx == ERR);
      if (accept) begin
        size_q   <= size;
        ofs_q    <= addr[1:0];
        wdata_q  <= wdata;
        mem_addr <= {addr[31:2], 2'b00};
        if (state_nx == WRITE) mem_wdata <= wdata;
      end
      if (capture) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
// tb/tb_store_size_unit.sv - directed bench for store_size_unit at read latencies 1 and 3
module tb_store_size_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rd1, rd3, ma1, ma3, wd1, wd3;
  logic        wr1, wr3, busy1, busy3, done1, done3, err1, err3;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  int          wc1 = 0, wc3 = 0;
  int          checks = 0, errors = 0;
  bit          sel = 1'b0;
  int          wc0;
  logic [31:0] v_busy, v_done, v_err, v_wr, v_addr, v_wdata;

  always #5 clk = ~clk;

  store_size_unit #(.MEM_RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr), .wdata(wdata),
    .mem_rdata(rd1), .mem_addr(ma1), .mem_wdata(wd1), .mem_wr(wr1),
    .busy(busy1), .done(done1), .err(err1)
  );

  store_size_unit #(.MEM_RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr), .wdata(wdata),
    .mem_rdata(rd3), .mem_addr(ma3), .mem_wdata(wd3), .mem_wr(wr3),
    .busy(busy3), .done(done3), .err(err3)
  );

  assign rd1 = mem1[ma1[9:2]];
  assign rd3 = mem3[ma3[9:2]];

  always @(posedge clk) begin
    if (wr1) begin
      mem1[ma1[9:2]] <= wd1;
      wc1 <= wc1 + 1;
    end
    if (wr3) begin
      mem3[ma3[9:2]] <= wd3;
      wc3 <= wc3 + 1;
    end
  end

  assign v_busy  = {31'd0, sel ? busy3 : busy1};
  assign v_done  = {31'd0, sel ? done3 : done1};
  assign v_err   = {31'd0, sel ? err3 : err1};
  assign v_wr    = {31'd0, sel ? wr3 : wr1};
  assign v_addr  = sel ? ma3 : ma1;
  assign v_wdata = sel ? wd3 : wd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one store from a negedge and follow it cycle by cycle until IDLE.
  task automatic run(input int lat, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ea, input logic [31:0] ew,
                     input bit e);
    int w0;
    int nrd;
    w0  = sel ? wc3 : wc1;
    nrd = (sz == 2'b00) ? 0 : lat;
    size = sz; addr = a; wdata = d;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    size = 2'b11; addr = 32'hFFFF_FFFC; wdata = ~d;
    @(negedge clk);
    if (e) begin
      chk("err_done", v_done, 32'd1);
      chk("err_err", v_err, 32'd1);
      chk("err_busy", v_busy, 32'd1);
      chk("err_wr", v_wr, 32'd0);
    end else begin
      for (int c = 0; c < nrd; c++) begin
        chk("rd_busy", v_busy, 32'd1);
        chk("rd_wr", v_wr, 32'd0);
        chk("rd_addr", v_addr, ea);
        @(negedge clk);
      end
      chk("wr_strobe", v_wr, 32'd1);
      chk("wr_data", v_wdata, ew);
      chk("wr_addr", v_addr, ea);
      chk("wr_done", v_done, 32'd0);
      @(negedge clk);
      chk("done", v_done, 32'd1);
      chk("done_err", v_err, 32'd0);
      chk("done_wr", v_wr, 32'd0);
      chk("done_busy", v_busy, 32'd1);
      chk("done_addr", v_addr, ea);
    end
    @(negedge clk);
    chk("idle_busy", v_busy, 32'd0);
    chk("idle_done", v_done, 32'd0);
    chk("wr_count", (sel ? wc3 : wc1) - w0, e ? 32'd0 : 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    #12;
    chk("rst_addr", ma1, 32'd0);
    chk("rst_wdata", wd1, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_wr", {31'd0, wr1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_err", {31'd0, err3}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    sel = 1'b0;
    mem1[8'h40] = 32'hAABBCCDD;
    run(1, 2'b10, 32'h102, 32'h12345677, 32'h100, 32'hAA77CCDD, 1'b0);
    chk("mem_byte2", mem1[8'h40], 32'hAA77CCDD);

    mem1[8'h40] = 32'hAABBCCDD;
    run(1, 2'b10, 32'h103, 32'h00000011, 32'h100, 32'h11BBCCDD, 1'b0);
    chk("mem_byte3", mem1[8'h40], 32'h11BBCCDD);

    mem1[8'h40] = 32'hAABBCCDD;
    run(1, 2'b01, 32'h102, 32'h0000BEEF, 32'h100, 32'hBEEFCCDD, 1'b0);
    chk("mem_half_hi", mem1[8'h40], 32'hBEEFCCDD);

    mem1[8'h40] = 32'hAABBCCDD;
    run(1, 2'b01, 32'h100, 32'h0000BEEF, 32'h100, 32'hAABBBEEF, 1'b0);
    chk("mem_half_lo", mem1[8'h40], 32'hAABBBEEF);

    run(1, 2'b00, 32'h107, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF, 1'b0);
    chk("mem_word", mem1[8'h41], 32'hDEADBEEF);

    mem1[8'h40] = 32'hAABBCCDD;
    run(1, 2'b01, 32'h101, 32'h0000BEEF, 32'h100, 32'd0, 1'b1);
    run(1, 2'b11, 32'h100, 32'h12345678, 32'h100, 32'd0, 1'b1);
    chk("mem_err", mem1[8'h40], 32'hAABBCCDD);

    // starts during RD_WAIT and during done are dropped
    wc0 = wc1;
    size = 2'b10; addr = 32'h101; wdata = 32'h66; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    chk("bz_rd_busy", v_busy, 32'd1);
    size = 2'b00; addr = 32'h200; wdata = 32'h0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    chk("bz_wr", v_wr, 32'd1);
    chk("bz_wdata", v_wdata, 32'hAABB66DD);
    chk("bz_addr", v_addr, 32'h100);
    @(negedge clk);
    chk("bz_done", v_done, 32'd1);
    start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    chk("bz_idle", v_busy, 32'd0);
    chk("bz_count", wc1 - wc0, 32'd1);
    chk("bz_untouched", mem1[8'h80], 32'd0);
    run(1, 2'b00, 32'h208, 32'hCAFEF00D, 32'h208, 32'hCAFEF00D, 1'b0);
    chk("mem_after_idle", mem1[8'h82], 32'hCAFEF00D);

    // asynchronous reset in the middle of a latency-3 read wait
    sel = 1'b1;
    mem3[8'h40] = 32'hAABBCCDD;
    wc0 = wc3;
    size = 2'b10; addr = 32'h101; wdata = 32'h55; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    @(negedge clk);
    chk("rs_busy1", v_busy, 32'd1);
    @(negedge clk);
    chk("rs_busy2", v_busy, 32'd1);
    chk("rs_wr", v_wr, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rs_async_busy", v_busy, 32'd0);
    chk("rs_async_wr", v_wr, 32'd0);
    chk("rs_async_done", v_done, 32'd0);
    chk("rs_async_addr", v_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rs_mem", mem3[8'h40], 32'hAABBCCDD);
    chk("rs_count", wc3 - wc0, 32'd0);
    run(3, 2'b10, 32'h103, 32'h00000099, 32'h100, 32'h99BBCCDD, 1'b0);
    chk("rs_mem_after", mem3[8'h40], 32'h99BBCCDD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
